systolic_seq: RTL and testbench
===============================

Name: systolic_seq

Overview:
- Sequencer for an N x N output-stationary systolic array of 16-bit signed MAC cells.
- On start it does three things:
  - Clears the array accumulators.
  - Streams k_len columns of A and k_len rows of B from an operand buffer with 1-cycle read latency, applying the per-lane diagonal skew.
  - Holds array clock-enable high until the last product has landed, then pulses done.
- Sits between the operand buffers/host control and the MAC array edges: west lanes carry A, north lanes carry B.

Parameters:
- N, 4, array dimension (lanes per edge), N >= 2.
- DW, 16, operand width per lane.
- K_MAX, 64, maximum inner dimension per job.
- KW, 7, width of k_len; KW = clog2(K_MAX+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE, no done.
- k_len  in  KW  inner dimension; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- rd_en  out  1  operand buffer read strobe.
- rd_k  out  KW  operand buffer read index.
- a_col_data  in  N*DW  column rd_k of A, lane i = row i; valid 1 cycle after rd_en.
- b_row_data  in  N*DW  row rd_k of B, lane j = column j; valid 1 cycle after rd_en.
- west_bus  out  N*DW  skewed A lanes to the array west edge.
- north_bus  out  N*DW  skewed B lanes to the array north edge.
- array_ce  out  1  clock enable to all MAC cells.
- array_clr  out  1  synchronous accumulator clear to all MAC cells.
- perf_cycles  out  32  busy-cycle count of the last job (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; skew registers 0; state IDLE.
- Reset mid-job aborts immediately, with no done.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and k_len=0: go to DONE (no clear, no ce).
  - start=1 and k_len>0: latch k_eff = min(k_len, K_MAX); go to CLEAR.
- CLEAR: one cycle, array_clr=1, array_ce=0; go to FEED.
- FEED: k_eff cycles.
  - rd_en=1; rd_k counts 0..k_eff-1; array_ce=1.
  - After the last index, go to DRAIN.
- DRAIN: 2N-1 cycles, array_ce=1, rd_en=0.
  - Covers 1 cycle of read latency plus 2(N-1) cycles of propagation to cell (N-1,N-1).
  - Then go to DONE.
- DONE: one cycle, done=1, array_ce=0; go to IDLE.
- Job length: busy is high for exactly 1 + k_eff + 2N-1 + 1 cycles. For k_len=0, busy is high 1 cycle (DONE only).
- Data valid flag: set one cycle after rd_en. While it is clear, lanes inject 0, so padding adds 0 to every accumulator.
- Skew:
  - West lane i passes through i register stages before west_bus lane i.
  - North lane j passes through j register stages before north_bus lane j.
  - Lane 0 has zero added delay, so buffer data is driven combinationally through the valid mask.
  - Skew registers advance only while array_ce=1; they are flushed to 0 in CLEAR and on abort.
- Skew consequence: element k of A row i reaches west_bus lane i at cycle (first FEED cycle) + 1 + k + i. B is symmetric.
- Arithmetic: the sequencer performs no arithmetic on data. It passes DW-bit values unmodified; the signed interpretation belongs to the MAC cells.
- start asserted while busy: ignored, not queued.
- start and abort in the same cycle in IDLE: abort wins; remain IDLE.
- abort in any busy state: next cycle is IDLE with busy=0, array_ce=0, rd_en=0 and skew flushed. Accumulator contents are undefined.
- abort in DONE: done still pulses that cycle; abort has no further effect.
- Back-to-back jobs: start is legal in the first IDLE cycle after DONE, giving a minimum 1-cycle gap.
- k_len > K_MAX: clamped to K_MAX; only indices 0..K_MAX-1 are read.

Optional Feature:
- Macro: SYSTOLIC_SEQ_PERF_EN.
- Defined:
  - A 32-bit counter increments every busy cycle, saturating at 0xFFFFFFFF.
  - The counter clears on leaving IDLE.
  - perf_cycles updates with the final count in the DONE cycle and holds until the next DONE.
  - Reset clears it.
- Undefined: perf_cycles tied to 0 and no counter logic.

Test Plan:
- N=4, start with k_len=1, A col0=[1,2,3,4], B row0=[5,6,7,8] -> busy exactly 10 cycles; one array_clr pulse; west lane i non-zero only at FEED-start+1+i; done pulses once; model accumulator (i,j) = A[i]*B[j], e.g. (3,3)=32.
- N=4, k_len=4, A=B=identity, plus a signed case with A lanes=-1 (0xFFFF) -> busy 13 cycles; rd_k sequence 0,1,2,3; bench model of the array yields identity, and the signed case yields -B.
- k_len=0 -> busy 1 cycle, done next cycle, array_clr and array_ce never asserted, rd_en never asserted.
- k_len=100 with K_MAX=64 -> rd_k stops at 63; busy 1+64+7+1=73 cycles.
- abort in the 3rd FEED cycle, with start re-asserted in the same cycle -> next cycle IDLE, all lanes 0, array_ce=0, no done; start 2 cycles later runs a full clean job.
- Async rst mid-DRAIN, then a new job; with SYSTOLIC_SEQ_PERF_EN, a k_len=2 job -> outputs 0 on rst assertion without a clock edge; perf_cycles=11 after the k_len=2 job.

Source files
------------

// File: rtl/systolic_seq.sv
// Operand sequencer for an N x N output-stationary systolic MAC array.
// Define SYSTOLIC_SEQ_PERF_EN to add the busy-cycle performance counter.
module systolic_seq #(
   parameter int N     = 4,
   parameter int DW    = 16,
   parameter int K_MAX = 64,
   parameter int KW    = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [KW-1:0] k_len,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [KW-1:0] rd_k,
   input  logic [N*DW-1:0] a_col_data,
   input  logic [N*DW-1:0] b_row_data,
   output logic [N*DW-1:0] west_bus,
   output logic [N*DW-1:0] north_bus,
   output logic          array_ce,
   output logic          array_clr,
   output logic [31:0]   perf_cycles
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } state_t;

   localparam int CW = $clog2(2 * N);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);
   localparam logic [KW-1:0] KMAX_V = KW'(K_MAX);

   state_t        state_q, state_d;
   logic [KW-1:0] k_eff_q, k_eff_d;
   logic [KW-1:0] rd_k_q, rd_k_d;
   logic [CW-1:0] dcnt_q, dcnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rd_en_q, rd_en_d;
   logic          ce_q, ce_d;
   logic          clr_q, clr_d;
   logic          valid_q, valid_d;
   logic          flush;

   always_comb begin
      state_d = state_q;
      k_eff_d = k_eff_q;
      flush   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (k_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = CLEAR;
                  k_eff_d = (k_len > KMAX_V) ? KMAX_V : k_len;
               end
            end
         end
         CLEAR: state_d = FEED;
         FEED: begin
            if (rd_k_q == k_eff_q - KW'(1))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (dcnt_q == DRAIN_LAST)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort in DONE is a no-op: the pulse is already on the wire
      if (abort && state_q != IDLE && state_q != DONE) begin
         state_d = IDLE;
         flush   = 1'b1;
      end
      if (state_q == CLEAR)
         flush = 1'b1;
      rd_k_d = (state_q == FEED && state_d == FEED) ?
               rd_k_q + KW'(1) : '0;
      dcnt_d = (state_q == DRAIN && state_d == DRAIN) ?
               dcnt_q + CW'(1) : '0;
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      rd_en_d = (state_d == FEED);
      ce_d    = (state_d == FEED) || (state_d == DRAIN);
      clr_d   = (state_d == CLEAR);
      valid_d = flush ? 1'b0 : rd_en_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_eff_q <= '0;
         rd_k_q  <= '0;
         dcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         ce_q    <= 1'b0;
         clr_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_eff_q <= k_eff_d;
         rd_k_q  <= rd_k_d;
         dcnt_q  <= dcnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
         ce_q    <= ce_d;
         clr_q   <= clr_d;
         valid_q <= valid_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_k      = rd_k_q;
   assign array_ce  = ce_q;
   assign array_clr = clr_q;

   // Buffer data is masked to zero whenever no read is in flight.
   logic [DW-1:0] a_in [N];
   logic [DW-1:0] b_in [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_in[i] = valid_q ? a_col_data[i*DW +: DW] : '0;
         b_in[i] = valid_q ? b_row_data[i*DW +: DW] : '0;
      end
   end

   assign west_bus[0 +: DW]  = a_in[0];
   assign north_bus[0 +: DW] = b_in[0];

   for (genvar i = 1; i < N; i++) begin : g_skew
      logic [DW-1:0] w_q [i];
      logic [DW-1:0] w_d [i];
      logic [DW-1:0] n_q [i];
      logic [DW-1:0] n_d [i];

      always_comb begin
         for (int s = 0; s < i; s++) begin
            w_d[s] = w_q[s];
            n_d[s] = n_q[s];
         end
         if (flush) begin
            for (int s = 0; s < i; s++) begin
               w_d[s] = '0;
               n_d[s] = '0;
            end
         end else if (ce_q) begin
            w_d[0] = a_in[i];
            n_d[0] = b_in[i];
            for (int s = 1; s < i; s++) begin
               w_d[s] = w_q[s-1];
               n_d[s] = n_q[s-1];
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s < i; s++) begin
               w_q[s] <= '0;
               n_q[s] <= '0;
            end
         end else begin
            for (int s = 0; s < i; s++) begin
               w_q[s] <= w_d[s];
               n_q[s] <= n_d[s];
            end
         end
      end

      assign west_bus[i*DW +: DW]  = w_q[i-1];
      assign north_bus[i*DW +: DW] = n_q[i-1];
   end

`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0] pcnt_q, pcnt_d;
   logic [31:0] perf_q, perf_d;

   always_comb begin
      pcnt_d = pcnt_q;
      perf_d = perf_q;
      if (state_q == IDLE) begin
         if (state_d != IDLE)
            pcnt_d = 32'd1;
      end else if (state_d != IDLE && pcnt_q != '1) begin
         pcnt_d = pcnt_q + 32'd1;
      end
      if (state_d == DONE)
         perf_d = pcnt_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q <= '0;
         perf_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: random operands, a behavioural output-stationary
// array model, and job timing checks against the sequencer rules.
module tb_systolic_seq;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int K_MAX = 64;
   localparam int KW    = 7;
   localparam int MAXC  = 200;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            abort;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            rd_en;
   logic [KW-1:0]   rd_k;
   logic [N*DW-1:0] a_col_data;
   logic [N*DW-1:0] b_row_data;
   logic [N*DW-1:0] west_bus;
   logic [N*DW-1:0] north_bus;
   logic            array_ce;
   logic            array_clr;
   logic [31:0]     perf_cycles;

   systolic_seq #(.N(N), .DW(DW), .K_MAX(K_MAX), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .k_len(k_len), .busy(busy), .done(done), .rd_en(rd_en),
      .rd_k(rd_k), .a_col_data(a_col_data), .b_row_data(b_row_data),
      .west_bus(west_bus), .north_bus(north_bus),
      .array_ce(array_ce), .array_clr(array_clr),
      .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   // A[k][i]: row i, column k of A.  B[k][j]: row k, column j of B.
   logic [DW-1:0] A [K_MAX][N];
   logic [DW-1:0] B [K_MAX][N];

   // Operand buffer, 1-cycle read latency; junk when not read.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         a_col_data[i*DW +: DW] <= rd_en ? A[rd_k][i] : DW'($urandom);
         b_row_data[i*DW +: DW] <= rd_en ? B[rd_k][i] : DW'($urandom);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] wt [MAXC][N];
   logic [DW-1:0] nt [MAXC][N];
   bit            ce_t [MAXC];
   int n_busy, n_clr, n_ce, n_done, n_rd;
   int rd_bad, clr_bad, done_bad, bus_err, acc_err;
   int cm [N][N];
   logic [31:0] perf_obs;

`ifdef SYSTOLIC_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   task automatic fill_zero;
      for (int k = 0; k < K_MAX; k++)
         for (int i = 0; i < N; i++) begin
            A[k][i] = '0;
            B[k][i] = '0;
         end
   endtask

   task automatic fill_rand;
      for (int k = 0; k < K_MAX; k++)
         for (int i = 0; i < N; i++) begin
            A[k][i] = DW'($urandom);
            B[k][i] = DW'($urandom);
         end
   endtask

   // Launch one job at a negedge and capture it until busy falls.
   task automatic run_job(input int kl, input int hold);
      int ke;
      ke = (kl > K_MAX) ? K_MAX : kl;
      n_busy = 0; n_clr = 0; n_ce = 0; n_done = 0; n_rd = 0;
      rd_bad = 0; clr_bad = 0; done_bad = 0;
      bus_err = 0; acc_err = 0;
      for (int t = 0; t < MAXC; t++) ce_t[t] = 1'b0;
      k_len = KW'(kl);
      start = 1'b1;
      for (int t = 0; t < MAXC; t++) begin
         @(negedge clk);
         if (t + 1 >= hold) start = 1'b0;
         if (!busy) break;
         n_busy++;
         if (array_clr) begin
            n_clr++;
            if (t != 0) clr_bad++;
         end
         if (array_ce) begin
            n_ce++;
            ce_t[t] = 1'b1;
         end
         if (done) n_done++;
         if (done != (kl == 0 ? (t == 0) : (t == ke + 2 * N)))
            done_bad++;
         if (rd_en) begin
            if (int'(rd_k) != n_rd) rd_bad++;
            n_rd++;
         end
         for (int i = 0; i < N; i++) begin
            wt[t][i] = west_bus[i*DW +: DW];
            nt[t][i] = north_bus[i*DW +: DW];
         end
      end
      start = 1'b0;
      perf_obs = perf_cycles;
      // element k of lane i is due at job cycle 2+k+i
      for (int t = 0; t < n_busy; t++)
         for (int i = 0; i < N; i++) begin
            int k;
            k = t - 2 - i;
            if (wt[t][i] !== ((k >= 0 && k < ke) ? A[k][i] : '0))
               bus_err++;
            if (nt[t][i] !== ((k >= 0 && k < ke) ? B[k][i] : '0))
               bus_err++;
         end
      // array model: cell(i,j) sees west lane i j cycles late and
      // north lane j i cycles late, accumulating on every ce cycle
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int acc, ref_v;
            acc = 0;
            ref_v = 0;
            for (int t = 0; t < n_busy; t++) begin
               if (ce_t[t] && t >= j && t >= i)
                  acc += int'($signed(wt[t-j][i])) *
                         int'($signed(nt[t-i][j]));
            end
            for (int k = 0; k < ke; k++)
               ref_v += int'($signed(A[k][i])) * int'($signed(B[k][j]));
            cm[i][j] = acc;
            if (acc != ref_v) acc_err++;
         end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, rd_en, rd_k, west_bus, north_bus, array_ce,
           array_clr, perf_cycles} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got busy=%b ce=%b west=%h want all 0",
                  busy, array_ce, west_bus);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_k1;
      fill_zero;
      for (int i = 0; i < N; i++) begin
         A[0][i] = DW'(i + 1);
         B[0][i] = DW'(i + 5);
      end
      run_job(1, 1);
      n_cmp++;
      if (n_busy != 10) begin
         n_bad++;
         $display("FAIL k1_busy got %0d want 10", n_busy);
      end
      n_cmp++;
      if (n_clr != 1 || clr_bad != 0) begin
         n_bad++;
         $display("FAIL k1_clr got %0d pulses (%0d late) want 1", n_clr, clr_bad);
      end
      n_cmp++;
      if (n_done != 1 || done_bad != 0) begin
         n_bad++;
         $display("FAIL k1_done got %0d (%0d misplaced) want 1", n_done, done_bad);
      end
      n_cmp++;
      if (bus_err != 0) begin
         n_bad++;
         $display("FAIL k1_skew got %0d bad lane samples want 0", bus_err);
      end
      n_cmp++;
      if (cm[3][3] != 32 || acc_err != 0) begin
         n_bad++;
         $display("FAIL k1_acc got c33=%0d errs=%0d want 32/0", cm[3][3], acc_err);
      end
      n_cmp++;
      if (perf_obs !== (PERF ? 32'd10 : 32'd0)) begin
         n_bad++;
         $display("FAIL k1_perf got %0d want %0d", perf_obs, PERF ? 10 : 0);
      end
   endtask

   task automatic test_identity;
      fill_zero;
      for (int i = 0; i < N; i++) begin
         A[i][i] = DW'(1);
         B[i][i] = DW'(1);
      end
      run_job(4, 1);
      n_cmp++;
      if (n_busy != 13) begin
         n_bad++;
         $display("FAIL ident_busy got %0d want 13", n_busy);
      end
      n_cmp++;
      if (n_rd != 4 || rd_bad != 0) begin
         n_bad++;
         $display("FAIL ident_rdk got %0d reads (%0d out of order) want 4", n_rd, rd_bad);
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (cm[i][j] != ((i == j) ? 1 : 0)) begin
               n_bad++;
               $display("FAIL ident_c%0d%0d got %0d want %0d",
                        i, j, cm[i][j], (i == j) ? 1 : 0);
            end
         end
      fill_rand;
      for (int k = 0; k < N; k++)
         for (int i = 0; i < N; i++)
            A[k][i] = (k == i) ? 16'hFFFF : 16'h0000;
      run_job(4, 1);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (cm[i][j] != -int'($signed(B[i][j]))) begin
               n_bad++;
               $display("FAIL neg_c%0d%0d got %0d want %0d",
                        i, j, cm[i][j], -int'($signed(B[i][j])));
            end
         end
   endtask

   task automatic test_zero_len;
      run_job(0, 1);
      n_cmp++;
      if (n_busy != 1 || n_done != 1 || done_bad != 0) begin
         n_bad++;
         $display("FAIL zero_len got busy=%0d done=%0d want 1/1", n_busy, n_done);
      end
      n_cmp++;
      if (n_clr != 0 || n_ce != 0 || n_rd != 0) begin
         n_bad++;
         $display("FAIL zero_quiet got clr=%0d ce=%0d rd=%0d want 0/0/0",
                  n_clr, n_ce, n_rd);
      end
   endtask

   task automatic test_clamp;
      fill_rand;
      run_job(100, 1);
      n_cmp++;
      if (n_busy != 73) begin
         n_bad++;
         $display("FAIL clamp_busy got %0d want 73", n_busy);
      end
      n_cmp++;
      if (n_rd != 64 || rd_bad != 0) begin
         n_bad++;
         $display("FAIL clamp_rdk got %0d reads (%0d bad) want 64", n_rd, rd_bad);
      end
      n_cmp++;
      if (acc_err != 0 || bus_err != 0) begin
         n_bad++;
         $display("FAIL clamp_data got acc=%0d bus=%0d errs want 0", acc_err, bus_err);
      end
   endtask

   // Back-to-back jobs, with start held into busy on some of them.
   task automatic test_back_to_back;
      for (int r = 0; r < 5; r++) begin
         int kl, hold;
         kl = $urandom_range(1, 12);
         hold = $urandom_range(1, 3);
         fill_rand;
         run_job(kl, hold);
         n_cmp++;
         if (n_busy != kl + 2 * N + 1 || n_ce != kl + 2 * N - 1) begin
            n_bad++;
            $display("FAIL b2b%0d_len got busy=%0d ce=%0d want %0d/%0d",
                     r, n_busy, n_ce, kl + 2 * N + 1, kl + 2 * N - 1);
         end
         n_cmp++;
         if (acc_err != 0 || bus_err != 0 || done_bad != 0) begin
            n_bad++;
            $display("FAIL b2b%0d_data got acc=%0d bus=%0d done=%0d errs want 0",
                     r, acc_err, bus_err, done_bad);
         end
      end
   endtask

   task automatic test_abort;
      start = 1'b1; abort = 1'b1; k_len = KW'(3);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_idle got busy=%b want 0", busy);
      end
      fill_rand;
      k_len = KW'(8);
      start = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_cmp++;
      if (rd_en !== 1'b1 || rd_k !== KW'(2)) begin
         n_bad++;
         $display("FAIL abort_pre got rd_en=%b rd_k=%0d want 1/2", rd_en, rd_k);
      end
      abort = 1'b1; start = 1'b1; k_len = KW'(5);
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      n_cmp++;
      if ({busy, array_ce, rd_en, done, west_bus, north_bus} !== '0) begin
         n_bad++;
         $display("FAIL abort_flush got busy=%b ce=%b rd=%b done=%b west=%h north=%h want 0",
                  busy, array_ce, rd_en, done, west_bus, north_bus);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_noqueue got busy=%b done=%b want 0/0", busy, done);
      end
      fill_rand;
      run_job(5, 1);
      n_cmp++;
      if (n_busy != 14 || acc_err != 0 || bus_err != 0 || n_clr != 1) begin
         n_bad++;
         $display("FAIL abort_rerun got busy=%0d acc=%0d bus=%0d clr=%0d want 14/0/0/1",
                  n_busy, acc_err, bus_err, n_clr);
      end
   endtask

   task automatic test_rst_drain;
      fill_rand;
      k_len = KW'(3);
      start = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_cmp++;
      if (busy !== 1'b1 || array_ce !== 1'b1 || rd_en !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_pre got busy=%b ce=%b rd=%b want 1/1/0",
                  busy, array_ce, rd_en);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, rd_en, rd_k, west_bus, north_bus, array_ce,
           array_clr, perf_cycles} !== '0) begin
         n_bad++;
         $display("FAIL rst_async got busy=%b ce=%b west=%h north=%h want all 0",
                  busy, array_ce, west_bus, north_bus);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      fill_rand;
      run_job(2, 1);
      n_cmp++;
      if (n_busy != 11 || acc_err != 0 || n_done != 1) begin
         n_bad++;
         $display("FAIL rst_rerun got busy=%0d acc=%0d done=%0d want 11/0/1",
                  n_busy, acc_err, n_done);
      end
      n_cmp++;
      if (perf_obs !== (PERF ? 32'd11 : 32'd0)) begin
         n_bad++;
         $display("FAIL perf_k2 got %0d want %0d", perf_obs, PERF ? 11 : 0);
      end
   endtask

   initial begin
      test_reset;
      test_k1;
      test_identity;
      test_zero_len;
      test_clamp;
      test_back_to_back;
      test_abort;
      test_rst_drain;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
